axi_lite_csr_adapter: RTL and testbench
=======================================

// Module: axi_lite_csr_adapter
// PURPOSE
//   AXI-Lite sink that terminates the output of the AXI-Lite pipeline bridge and drives a flat
//   CSR strobe interface: single-cycle write pulse, read request with ack.
//   One transaction in flight at a time; write and read channels are arbitrated.
//   Reads time out with SLVERR if no ack arrives. Misaligned accesses get SLVERR.
// PARAMETERS
//   ADDR_W      20   AXI-Lite / CSR address width
//   DATA_W      64   data width, 32 or 64; BYTE_LSB = log2(DATA_W/8)
//   RD_TIMEOUT  64   cycles to wait for csr_rd_ack before SLVERR, >=2
// PORTS
//   clk          in   1         clock
//   rst_n        in   1         synchronous active-low reset
//   s_awvalid    in   1         AW valid
//   s_awready    out  1         AW ready
//   s_awaddr     in   ADDR_W    write address
//   s_wvalid     in   1         W valid
//   s_wready     out  1         W ready
//   s_wdata      in   DATA_W    write data
//   s_wstrb      in   DATA_W/8  byte strobes
//   s_bvalid     out  1         B valid
//   s_bready     in   1         B ready
//   s_bresp      out  2         00 OKAY, 10 SLVERR
//   s_arvalid    in   1         AR valid
//   s_arready    out  1         AR ready
//   s_araddr     in   ADDR_W    read address
//   s_rvalid     out  1         R valid
//   s_rready     in   1         R ready
//   s_rdata      out  DATA_W    read data
//   s_rresp      out  2         00 OKAY, 10 SLVERR
//   csr_wr       out  1         one-cycle write strobe
//   csr_rd       out  1         one-cycle read request
//   csr_addr     out  ADDR_W    address for csr_wr/csr_rd, held from strobe to response
//   csr_wdata    out  DATA_W    write data, valid with csr_wr
//   csr_wstrb    out  DATA_W/8  byte enables, valid with csr_wr
//   csr_rdata    in   DATA_W    read data, sampled when csr_rd_ack=1
//   csr_rd_ack   in   1         read data valid; 1 cycle
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): all outputs 0, holding regs empty, FSM IDLE, last_grant=RD.
//     Readys rise the first cycle after reset release. Reset mid-transaction discards it; no response.
//   - Holding regs: AW and W captured independently.
//     s_awready = ~aw_full & state==IDLE. s_wready = ~w_full & state==IDLE.
//     s_arready = ~ar_full & state==IDLE. All readys are registered, not combinational on valid.
//   - Write pending = aw_full & w_full; read pending = ar_full.
//   - FSM IDLE->WRITE / READ. If both pending, grant opposite of last_grant (reset => write first).
//   - WRITE: 1 cycle. If addr[BYTE_LSB-1:0]!=0, bresp=SLVERR and no csr_wr.
//     Else if wstrb==0, bresp=OKAY and no csr_wr. Else csr_wr=1, bresp=OKAY.
//     Clear aw/w regs; ->WR_RESP.
//   - WR_RESP: s_bvalid=1, bresp stable until s_bready; then ->IDLE.
//   - READ: misaligned -> rresp=SLVERR, rdata=0, no csr_rd, ->RD_RESP.
//     Else csr_rd=1 in the first READ cycle only; timeout counter starts at 1.
//     csr_rd_ack accepted from that cycle on: latch rdata, rresp=OKAY, ->RD_RESP.
//     Counter==RD_TIMEOUT without ack: rdata=0, rresp=SLVERR, ->RD_RESP. Ack in the same cycle wins.
//   - RD_RESP: s_rvalid=1, data stable until s_rready; then ->IDLE. Clear ar reg.
//   - csr_rd_ack outside READ is ignored (late ack after timeout).
//   - Latency (0-wait CSR, ready sinks): AW+W handshake c0 -> csr_wr c1 -> bvalid c2.
//     AR handshake c0 -> csr_rd c1 (ack c1) -> rvalid c2.
//   - Readys are low from grant until the response handshake; new beats may be captured
//     only while IDLE and the slot is empty.
// TESTING
//   1. Write addr 0x100, data 0xDEADBEEF_01234567, strb 0xFF -> csr_wr pulse c1 with those values; bvalid c2, bresp=00.
//   2. W precedes AW by 3 cycles -> single csr_wr after AW arrives; exactly one B.
//   3. Read 0x208, ack 5 cycles after csr_rd with 0x55 -> rdata=0x55, rresp=00; csr_rd high 1 cycle only.
//   4. Read, no ack, RD_TIMEOUT=64 -> rvalid at counter 64, rresp=10, rdata=0; ack at +70 ignored.
//   5. AW+W and AR valid same cycle after reset -> write served first, then read; repeat -> alternate.
//   6. Write addr 0x104 (DATA_W=64) -> no csr_wr, bresp=10.
//      rst_n low during RD wait -> all outputs 0, no R beat.

Source files
------------

// File: rtl/axi_lite_csr_adapter.sv
// axi_lite_csr_adapter
//   AXI-Lite sink that turns AW/W/AR traffic into a flat CSR strobe interface:
//   a one-cycle csr_wr pulse for writes, and a one-cycle csr_rd request answered
//   by csr_rd_ack for reads. One transaction is in flight at a time; when a write
//   and a read are both pending, the grant alternates, starting with the write
//   after reset. Misaligned accesses and reads without an ack in RD_TIMEOUT
//   cycles get SLVERR.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   s_aw*/s_w*/s_b*                 AXI-Lite write address / data / response
//   s_ar*/s_r*                      AXI-Lite read address / data
//   csr_wr, csr_rd                  one-cycle write strobe / read request
//   csr_addr                        address, held from strobe until the next grant
//   csr_wdata, csr_wstrb            write data and byte enables, valid with csr_wr
//   csr_rdata, csr_rd_ack           read data, sampled while csr_rd_ack=1
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | accepting AW/W/AR beats into empty slots, arbitrating
// ST_WRITE   | csr_wr (if any) is on the bus, write response computed
// ST_WR_RESP | s_bvalid held until s_bready
// ST_READ    | csr_rd issued in the first cycle, waiting for ack/timeout
// ST_RD_RESP | s_rvalid held until s_rready

module axi_lite_csr_adapter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 64,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                csr_wr,
  output logic                csr_rd,
  output logic [ADDR_W-1:0]   csr_addr,
  output logic [DATA_W-1:0]   csr_wdata,
  output logic [DATA_W/8-1:0] csr_wstrb,
  input  logic [DATA_W-1:0]   csr_rdata,
  input  logic                csr_rd_ack
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int TMR_W    = $clog2(RD_TIMEOUT);
  // Down-counter loaded so that it hits zero in the RD_TIMEOUT-th READ cycle.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RD_TIMEOUT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_READ    = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_rd_q, last_grant_rd_d;
  logic                aw_full_q, aw_full_d;
  logic                w_full_q, w_full_d;
  logic                ar_full_q, ar_full_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [TMR_W-1:0]    rd_tmr_q, rd_tmr_d;
  logic                s_awready_q, s_awready_d;
  logic                s_wready_q, s_wready_d;
  logic                s_arready_q, s_arready_d;
  logic                s_bvalid_q, s_bvalid_d;
  logic [1:0]          s_bresp_q, s_bresp_d;
  logic                s_rvalid_q, s_rvalid_d;
  logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;
  logic [1:0]          s_rresp_q, s_rresp_d;
  logic                csr_wr_q, csr_wr_d;
  logic                csr_rd_q, csr_rd_d;
  logic [ADDR_W-1:0]   csr_addr_q, csr_addr_d;
  logic [DATA_W-1:0]   csr_wdata_q, csr_wdata_d;
  logic [STRB_W-1:0]   csr_wstrb_q, csr_wstrb_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_pend, rd_pend, grant_wr;
  logic csr_misaligned;

  always_comb begin
    state_d         = state_q;
    last_grant_rd_d = last_grant_rd_q;
    aw_full_d       = aw_full_q;
    w_full_d        = w_full_q;
    ar_full_d       = ar_full_q;
    aw_addr_d       = aw_addr_q;
    w_data_d        = w_data_q;
    w_strb_d        = w_strb_q;
    ar_addr_d       = ar_addr_q;
    rd_tmr_d        = rd_tmr_q;
    s_bvalid_d      = s_bvalid_q;
    s_bresp_d       = s_bresp_q;
    s_rvalid_d      = s_rvalid_q;
    s_rdata_d       = s_rdata_q;
    s_rresp_d       = s_rresp_q;
    csr_wr_d        = 1'b0;
    csr_rd_d        = 1'b0;
    csr_addr_d      = csr_addr_q;
    csr_wdata_d     = csr_wdata_q;
    csr_wstrb_d     = csr_wstrb_q;

    aw_hs = s_awvalid & s_awready_q;
    w_hs  = s_wvalid & s_wready_q;
    ar_hs = s_arvalid & s_arready_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_araddr;
    end

    // Arbitrate on the slot contents including beats landing this cycle, so a
    // handshake in c0 produces the CSR strobe in c1.
    wr_pend  = aw_full_d & w_full_d;
    rd_pend  = ar_full_d;
    grant_wr = wr_pend & (~rd_pend | last_grant_rd_q);

    csr_misaligned = (csr_addr_q[BYTE_LSB-1:0] != '0);

    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d         = ST_WRITE;
          last_grant_rd_d = 1'b0;
          csr_addr_d      = aw_addr_d;
          csr_wdata_d     = w_data_d;
          csr_wstrb_d     = w_strb_d;
          csr_wr_d        = (aw_addr_d[BYTE_LSB-1:0] == '0) & (|w_strb_d);
        end else if (rd_pend) begin
          state_d         = ST_READ;
          last_grant_rd_d = 1'b1;
          csr_addr_d      = ar_addr_d;
          csr_rd_d        = (ar_addr_d[BYTE_LSB-1:0] == '0);
          rd_tmr_d        = TMR_LOAD;
        end
      end
      ST_WRITE: begin
        aw_full_d  = 1'b0;
        w_full_d   = 1'b0;
        s_bvalid_d = 1'b1;
        s_bresp_d  = csr_misaligned ? RESP_SLVERR : RESP_OKAY;
        state_d    = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (s_bready) begin
          s_bvalid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        if (csr_misaligned) begin
          s_rvalid_d = 1'b1;
          s_rdata_d  = '0;
          s_rresp_d  = RESP_SLVERR;
          state_d    = ST_RD_RESP;
        end else if (csr_rd_ack) begin
          // An ack in the final timeout cycle still wins.
          s_rvalid_d = 1'b1;
          s_rdata_d  = csr_rdata;
          s_rresp_d  = RESP_OKAY;
          state_d    = ST_RD_RESP;
        end else if (rd_tmr_q == '0) begin
          s_rvalid_d = 1'b1;
          s_rdata_d  = '0;
          s_rresp_d  = RESP_SLVERR;
          state_d    = ST_RD_RESP;
        end else begin
          rd_tmr_d = rd_tmr_q - TMR_W'(1);
        end
      end
      ST_RD_RESP: begin
        if (s_rready) begin
          s_rvalid_d = 1'b0;
          ar_full_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Readys registered from next-cycle slot/state so they never depend on valid.
    s_awready_d = ~aw_full_d & (state_d == ST_IDLE);
    s_wready_d  = ~w_full_d & (state_d == ST_IDLE);
    s_arready_d = ~ar_full_d & (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_grant_rd_q <= 1'b1;
      aw_full_q       <= 1'b0;
      w_full_q        <= 1'b0;
      ar_full_q       <= 1'b0;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      ar_addr_q       <= '0;
      rd_tmr_q        <= '0;
      s_awready_q     <= 1'b0;
      s_wready_q      <= 1'b0;
      s_arready_q     <= 1'b0;
      s_bvalid_q      <= 1'b0;
      s_bresp_q       <= '0;
      s_rvalid_q      <= 1'b0;
      s_rdata_q       <= '0;
      s_rresp_q       <= '0;
      csr_wr_q        <= 1'b0;
      csr_rd_q        <= 1'b0;
      csr_addr_q      <= '0;
      csr_wdata_q     <= '0;
      csr_wstrb_q     <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_rd_q <= last_grant_rd_d;
      aw_full_q       <= aw_full_d;
      w_full_q        <= w_full_d;
      ar_full_q       <= ar_full_d;
      aw_addr_q       <= aw_addr_d;
      w_data_q        <= w_data_d;
      w_strb_q        <= w_strb_d;
      ar_addr_q       <= ar_addr_d;
      rd_tmr_q        <= rd_tmr_d;
      s_awready_q     <= s_awready_d;
      s_wready_q      <= s_wready_d;
      s_arready_q     <= s_arready_d;
      s_bvalid_q      <= s_bvalid_d;
      s_bresp_q       <= s_bresp_d;
      s_rvalid_q      <= s_rvalid_d;
      s_rdata_q       <= s_rdata_d;
      s_rresp_q       <= s_rresp_d;
      csr_wr_q        <= csr_wr_d;
      csr_rd_q        <= csr_rd_d;
      csr_addr_q      <= csr_addr_d;
      csr_wdata_q     <= csr_wdata_d;
      csr_wstrb_q     <= csr_wstrb_d;
    end
  end

  assign s_awready = s_awready_q;
  assign s_wready  = s_wready_q;
  assign s_arready = s_arready_q;
  assign s_bvalid  = s_bvalid_q;
  assign s_bresp   = s_bresp_q;
  assign s_rvalid  = s_rvalid_q;
  assign s_rdata   = s_rdata_q;
  assign s_rresp   = s_rresp_q;
  assign csr_wr    = csr_wr_q;
  assign csr_rd    = csr_rd_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;
  assign csr_wstrb = csr_wstrb_q;

endmodule

// File: tb/tb_axi_lite_csr_adapter.sv
// Testbench for axi_lite_csr_adapter (ADDR_W=20, DATA_W=64, RD_TIMEOUT=64).
// Vector table for single transactions, hand sequences for split W/AW,
// arbitration, response hold and reset during a read wait.

module tb_axi_lite_csr_adapter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_awvalid = 1'b0, s_awready;
  logic [ADDR_W-1:0] s_awaddr = '0;
  logic s_wvalid = 1'b0, s_wready;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [STRB_W-1:0] s_wstrb = '0;
  logic s_bvalid, s_bready = 1'b1;
  logic [1:0] s_bresp;
  logic s_arvalid = 1'b0, s_arready;
  logic [ADDR_W-1:0] s_araddr = '0;
  logic s_rvalid, s_rready = 1'b1;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic csr_wr, csr_rd;
  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_wdata;
  logic [STRB_W-1:0] csr_wstrb;
  logic [DATA_W-1:0] csr_rdata;
  logic csr_rd_ack;

  axi_lite_csr_adapter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
    .csr_rdata(csr_rdata), .csr_rd_ack(csr_rd_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [166:0] all_outs;
  assign all_outs = {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata,
                     s_rresp, csr_wr, csr_rd, csr_addr, csr_wdata, csr_wstrb};

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard queues
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; logic [STRB_W-1:0] strb; } wr_exp_t;
  typedef struct { logic [DATA_W-1:0] data; logic [1:0] resp; } r_exp_t;
  wr_exp_t    exp_wr_q[$];
  logic [1:0] exp_b_q[$];
  r_exp_t     exp_r_q[$];

  // Monitor
  int csr_wr_cnt = 0, csr_rd_cnt = 0, b_cnt = 0, r_cnt = 0;
  int wr_cyc = -1, rd_cyc = -1, b_cyc = -1, r_cyc = -1;
  logic bvalid_prev = 1'b0, rvalid_prev = 1'b0;
  logic [ADDR_W-1:0] rd_addr_seen = '0;
  wr_exp_t m_we;
  r_exp_t  m_re;
  logic [1:0] m_be;

  initial forever begin
    @(negedge clk);
    if (csr_wr) begin
      csr_wr_cnt++;
      wr_cyc = cyc;
      if (exp_wr_q.size() == 0) check("csr_wr_unexpected", 1, 0);
      else begin
        m_we = exp_wr_q.pop_front();
        check("csr_wr_addr", csr_addr, m_we.addr);
        check("csr_wr_data", csr_wdata, m_we.data);
        check("csr_wr_strb", csr_wstrb, m_we.strb);
      end
    end
    if (csr_rd) begin
      csr_rd_cnt++;
      rd_cyc = cyc;
      rd_addr_seen = csr_addr;
    end
    if (s_bvalid && !bvalid_prev) b_cyc = cyc;
    if (s_rvalid && !rvalid_prev) r_cyc = cyc;
    bvalid_prev = s_bvalid;
    rvalid_prev = s_rvalid;
    if (s_bvalid && s_bready) begin
      b_cnt++;
      if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
      else begin
        m_be = exp_b_q.pop_front();
        check("bresp", s_bresp, m_be);
      end
    end
    if (s_rvalid && s_rready) begin
      r_cnt++;
      if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
      else begin
        m_re = exp_r_q.pop_front();
        check("rdata", s_rdata, m_re.data);
        check("rresp", s_rresp, m_re.resp);
      end
    end
  end

  // CSR responder: acks ack_dly cycles after csr_rd (0 = same cycle), never if negative.
  int ack_dly = 0;
  int ack_at = 0;
  bit ack_armed = 1'b0;
  logic [DATA_W-1:0] ack_data = '0;

  initial begin
    csr_rd_ack = 1'b0;
    csr_rdata = '0;
    forever begin
      @(negedge clk);
      csr_rd_ack = 1'b0;
      csr_rdata = '0;
      if (csr_rd && ack_dly >= 0) begin
        ack_armed = 1'b1;
        ack_at = cyc + ack_dly;
      end
      if (ack_armed && cyc == ack_at) begin
        csr_rd_ack = 1'b1;
        csr_rdata = ack_data;
        ack_armed = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_zero", 64'(|all_outs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("readys_after_reset", {s_awready, s_wready, s_arready}, 3'b111);
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [STRB_W-1:0] s, output int hs);
    bit aw_d = 0, w_d = 0;
    int t = 0;
    hs = -1;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while (!(aw_d && w_d) && t < 100) begin
      @(negedge clk); t++;
      if (s_awvalid && s_awready) aw_d = 1;
      if (s_wvalid && s_wready) w_d = 1;
      if (aw_d && w_d) hs = cyc;
      @(posedge clk); #1;
      if (aw_d) s_awvalid = 1'b0;
      if (w_d) s_wvalid = 1'b0;
    end
    if (hs < 0) begin
      check("write_handshake_timeout", 1, 0);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, output int hs);
    int t = 0;
    hs = -1;
    s_araddr = a;
    s_arvalid = 1'b1;
    while (hs < 0 && t < 100) begin
      @(negedge clk); t++;
      if (s_arvalid && s_arready) hs = cyc;
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    if (hs < 0) check("read_handshake_timeout", 1, 0);
  endtask

  task automatic axi_both(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                          input logic [ADDR_W-1:0] ra, output int hs);
    bit aw_d = 0, w_d = 0, ar_d = 0;
    int t = 0;
    hs = -1;
    s_awaddr = wa; s_wdata = wd; s_wstrb = 8'hFF; s_araddr = ra;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    while (!(aw_d && w_d && ar_d) && t < 100) begin
      @(negedge clk); t++;
      if (s_awvalid && s_awready) aw_d = 1;
      if (s_wvalid && s_wready) w_d = 1;
      if (s_arvalid && s_arready) ar_d = 1;
      if (aw_d && w_d && ar_d) hs = cyc;
      @(posedge clk); #1;
      if (aw_d) s_awvalid = 1'b0;
      if (w_d) s_wvalid = 1'b0;
      if (ar_d) s_arvalid = 1'b0;
    end
    if (hs < 0) begin
      check("both_handshake_timeout", 1, 0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_wr_q.size() != 0 || exp_b_q.size() != 0 || exp_r_q.size() != 0 || ack_armed)
           && t < 300) begin
      @(posedge clk); t++;
    end
    if (t >= 300) check({name, "_drain_timeout"}, 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string name; bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb; int ack_dly; logic [1:0] exp_resp; logic [DATA_W-1:0] exp_rdata;
    bit exp_strobe; int exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string name, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                         input int dly, input logic [1:0] resp, input logic [DATA_W-1:0] rdata,
                         input bit strobe, input int lat);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.ack_dly = dly;
    v.exp_resp = resp; v.exp_rdata = rdata; v.exp_strobe = strobe; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  vec_t v;
  int hs, wc0, rc0, bc0, r0;

  initial begin
    //      name          wr  addr       data / ack data         strb   dly resp   exp rdata  strb lat
    add_vec("w_basic",    1, 20'h00100, 64'hDEADBEEF_01234567, 8'hFF,  0, 2'b00, 64'h0,      1,  2);
    add_vec("w_misalign", 1, 20'h00104, 64'h1111_2222_3333_4444, 8'hFF, 0, 2'b10, 64'h0,     0,  2);
    add_vec("w_nostrb",   1, 20'h00108, 64'h2222,              8'h00,  0, 2'b00, 64'h0,      0,  2);
    add_vec("w_partial",  1, 20'h00000, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F, 0, 2'b00, 64'h0,     1,  2);
    add_vec("r_ack5",     0, 20'h00208, 64'h55,                8'h00,  5, 2'b00, 64'h55,     1,  7);
    add_vec("r_ack0",     0, 20'h00010, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 2'b00, 64'h0123_4567_89AB_CDEF, 1, 2);
    add_vec("r_misalign", 0, 20'h0000C, 64'h99,                8'h00,  0, 2'b10, 64'h0,      0,  2);
    add_vec("r_timeout",  0, 20'h00040, 64'h77,                8'h00, -1, 2'b10, 64'h0,      1, 65);
    add_vec("r_ack_last", 0, 20'h00048, 64'hCAFE,              8'h00, 63, 2'b00, 64'hCAFE,   1, 65);
    add_vec("r_late_ack", 0, 20'h00050, 64'hBAD,               8'h00, 70, 2'b10, 64'h0,      1, 65);

    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wc0 = csr_wr_cnt;
      rc0 = csr_rd_cnt;
      if (v.wr) begin
        if (v.exp_strobe) exp_wr_q.push_back('{v.addr, v.data, v.strb});
        exp_b_q.push_back(v.exp_resp);
        axi_write(v.addr, v.data, v.strb, hs);
        drain(v.name);
        check({v.name, "_csr_wr_count"}, 64'(csr_wr_cnt - wc0), 64'(v.exp_strobe));
        if (v.exp_strobe) check({v.name, "_csr_wr_lat"}, 64'(wr_cyc - hs), 1);
        check({v.name, "_b_lat"}, 64'(b_cyc - hs), 64'(v.exp_lat));
      end else begin
        ack_dly = v.ack_dly;
        ack_data = v.data;
        exp_r_q.push_back('{v.exp_rdata, v.exp_resp});
        axi_read(v.addr, hs);
        drain(v.name);
        check({v.name, "_csr_rd_count"}, 64'(csr_rd_cnt - rc0), 64'(v.exp_strobe));
        if (v.exp_strobe) begin
          check({v.name, "_csr_rd_lat"}, 64'(rd_cyc - hs), 1);
          check({v.name, "_csr_rd_addr"}, rd_addr_seen, v.addr);
        end
        check({v.name, "_r_lat"}, 64'(r_cyc - hs), 64'(v.exp_lat));
      end
    end

    // W arrives 3 cycles before AW: one strobe, one B.
    wc0 = csr_wr_cnt; bc0 = b_cnt;
    exp_wr_q.push_back('{20'h00300, 64'h0BAD_F00D_1234_5678, 8'hF0});
    exp_b_q.push_back(2'b00);
    s_wdata = 64'h0BAD_F00D_1234_5678; s_wstrb = 8'hF0; s_wvalid = 1'b1;
    hs = -1;
    for (int t = 0; t < 50 && hs < 0; t++) begin
      @(negedge clk);
      if (s_wready) hs = cyc;
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0;
    if (hs < 0) check("split_w_timeout", 1, 0);
    @(posedge clk); #1;
    check("split_wready_low_while_full", s_wready, 0);
    check("split_no_early_wr", 64'(csr_wr_cnt - wc0), 0);
    @(posedge clk); #1;
    s_awaddr = 20'h00300; s_awvalid = 1'b1;
    hs = -1;
    for (int t = 0; t < 50 && hs < 0; t++) begin
      @(negedge clk);
      if (s_awready) hs = cyc;
      @(posedge clk); #1;
    end
    s_awvalid = 1'b0;
    if (hs < 0) check("split_aw_timeout", 1, 0);
    drain("split");
    check("split_csr_wr_count", 64'(csr_wr_cnt - wc0), 1);
    check("split_csr_wr_lat", 64'(wr_cyc - hs), 1);
    check("split_b_count", 64'(b_cnt - bc0), 1);

    // Arbitration: after reset write first; again write first; after a lone write, read first.
    do_reset();
    ack_dly = 0; ack_data = 64'h1;
    exp_wr_q.push_back('{20'h00400, 64'hA1, 8'hFF}); exp_b_q.push_back(2'b00);
    exp_r_q.push_back('{64'h1, 2'b00});
    axi_both(20'h00400, 64'hA1, 20'h00500, hs);
    drain("arb1");
    check("arb1_wr_lat", 64'(wr_cyc - hs), 1);
    check("arb1_rd_lat", 64'(rd_cyc - hs), 4);

    ack_data = 64'h2;
    exp_wr_q.push_back('{20'h00408, 64'hA2, 8'hFF}); exp_b_q.push_back(2'b00);
    exp_r_q.push_back('{64'h2, 2'b00});
    axi_both(20'h00408, 64'hA2, 20'h00508, hs);
    drain("arb2");
    check("arb2_wr_lat", 64'(wr_cyc - hs), 1);
    check("arb2_rd_lat", 64'(rd_cyc - hs), 4);

    exp_wr_q.push_back('{20'h00410, 64'hA3, 8'hFF}); exp_b_q.push_back(2'b00);
    axi_write(20'h00410, 64'hA3, 8'hFF, hs);
    drain("arb3_lone");
    ack_data = 64'h3;
    exp_wr_q.push_back('{20'h00418, 64'hA4, 8'hFF}); exp_b_q.push_back(2'b00);
    exp_r_q.push_back('{64'h3, 2'b00});
    axi_both(20'h00418, 64'hA4, 20'h00518, hs);
    drain("arb3");
    check("arb3_rd_lat", 64'(rd_cyc - hs), 1);
    check("arb3_wr_lat", 64'(wr_cyc - hs), 4);

    // B held stable while bready is low.
    s_bready = 1'b0;
    exp_b_q.push_back(2'b10);
    axi_write(20'h00602, 64'h5, 8'hFF, hs);
    repeat (5) @(posedge clk);
    #1;
    check("b_hold_valid", s_bvalid, 1);
    check("b_hold_resp", s_bresp, 2'b10);
    check("b_hold_readys_low", {s_awready, s_wready, s_arready}, 3'b000);
    s_bready = 1'b1;
    drain("b_hold");

    // Reset while waiting for a read ack: outputs cleared, no R beat afterwards.
    ack_dly = -1;
    r0 = r_cnt;
    axi_read(20'h00700, hs);
    repeat (10) @(posedge clk);
    check("mid_rd_waiting", s_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rd_reset_outputs_zero", 64'(|all_outs), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("mid_rd_no_r_beat", 64'(r_cnt - r0), 0);

    // Recovery read after the mid-transaction reset.
    ack_dly = 2; ack_data = 64'h77;
    exp_r_q.push_back('{64'h77, 2'b00});
    axi_read(20'h00018, hs);
    drain("recover");
    check("recover_r_lat", 64'(r_cyc - hs), 4);

    check("queues_empty", 64'(exp_wr_q.size() + exp_b_q.size() + exp_r_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
